peak_limiter: RTL and testbench
===============================

# peak_limiter

Per-sample peak limiter on the 24 kHz, 16-bit signed output path. It sits between the allpass-corrected convolution output and the `pdm` modulator, and prevents full-scale overshoot from reaching the speaker. A peak envelope follower with hold and release drives a gain derived by a serial divider. The input is passed through bit-exact when the envelope is below threshold.

## Interface
- `THRESHOLD`, 16'sd24576: envelope level above which limiting engages (positive, 1..32767).
- `ATTACK_SHIFT`, 0: attack smoothing; env += (abs−env) >> ATTACK_SHIFT; 0 means instantaneous.
- `RELEASE_SHIFT`, 10: release decay; env −= max(env >> RELEASE_SHIFT, 1).
- `HOLD_SAMPLES`, 240: samples the envelope is held after the last rise before release starts (10 ms).

- `audio_clk` input 1: sole clock, 98.3 MHz.
- `rst_in_n` input 1: asynchronous, active-low reset.
- `sample_valid_in` input 1: one-cycle strobe; `audio_in` is valid on this cycle.
- `audio_in` input 16: signed sample.
- `sample_valid_out` output 1: one-cycle strobe; `audio_out` and `gain_out` are updated on this cycle.
- `audio_out` output 16: signed limited sample; registered and held between strobes.
- `gain_out` output 16: unsigned Q1.15 gain applied; 0x8000 is unity.
- `limiting_out` output 1: high while the last output sample was attenuated.
- `busy_out` output 1: high from sample capture through output.
- `limit_count` output 16: saturating count of attenuated samples (see Configuration).

## Operation
- States: IDLE, ENV, DIV, MUL, OUT.
- IDLE: on `sample_valid_in`, latch the sample, go to ENV.
- ENV:
  - abs = |x|, saturated (−32768 → 32767).
  - If abs > env: env updates per the attack rule; the hold counter loads HOLD_SAMPLES.
  - Else if hold counter ≠ 0: decrement it; env unchanged.
  - Else: env updates per the release rule, floored at 0.
- DIV:
  - Start `serial_divider` with numerator THRESHOLD<<15 and denominator env.
  - Runs exactly 16 cycles, unconditionally.
- MUL:
  - If env ≤ THRESHOLD: gain = 0x8000 and out = x, bit-exact.
  - Else: gain = quotient (< 0x8000) and out = (x·gain) >>> 15, an arithmetic shift (floor), saturated to 16 bits.
- OUT: register `audio_out`, `gain_out`, `limiting_out`; pulse `sample_valid_out`; return to IDLE.
- `sample_valid_in` while busy is ignored: the sample is dropped and state is unaffected. At 24 kHz there are 4096 cycles per sample, so this never occurs in the system.
- env is 16-bit unsigned; the hold counter is $clog2(HOLD_SAMPLES+1) bits.

## Timing
- Capture on cycle 0 (the `sample_valid_in` cycle).
- `sample_valid_out` on cycle 19, regardless of limiting: 1 ENV + 16 DIV + 1 MUL + 1 OUT.
- `busy_out` is high for cycles 1..19.
- Reset values:
  - `audio_out` = 0, `gain_out` = 0x8000.
  - `limiting_out`, `sample_valid_out`, `busy_out` = 0.
  - env = 0, hold counter = 0, `limit_count` = 0, state = IDLE.
- Reset asserted mid-operation aborts immediately: the in-flight sample is discarded and no `sample_valid_out` is issued.
- A `sample_valid_in` coinciding with the OUT cycle is dropped. The next sample is accepted from the cycle after OUT.

## Configuration
- `PEAK_LIMITER_STATS_EN` defined: `limit_count` increments on every OUT with `limiting_out` = 1, saturating at 0xFFFF; cleared only by reset.
- Undefined: `limit_count` is tied to 0 and the counter logic is absent.

## Structure
- Package `audio_pkg`:
  - `sample_t` (logic signed [15:0]).
  - `gain_t` (logic [15:0]).
  - `GAIN_UNITY` = 16'h8000.
  - `limiter_state_t` enum.
- Sub-module `serial_divider`: restoring radix-2, 31-bit numerator / 16-bit denominator, 16-bit quotient, `start`/`done` handshake, fixed 16-cycle latency. The quotient saturates at 0x7FFF; it is never exceeded because env > THRESHOLD whenever the quotient is used.

## Test plan
- Reset test:
  - Stimulus: assert `rst_in_n`=0 with no clock, then release.
  - Required: `audio_out`=0, `gain_out`=0x8000, all strobes 0.
- Sub-threshold sample:
  - Stimulus: 1000.
  - Required: `sample_valid_out` exactly 19 cycles later, `audio_out`=1000, `gain_out`=0x8000, `limiting_out`=0.
- Positive full scale:
  - Stimulus: 32767 (defaults).
  - Required: env=32767, `gain_out`=24576 (0x6000), `audio_out`=24575, `limiting_out`=1.
- Negative full scale:
  - Stimulus: −32768 immediately after the positive full-scale case.
  - Required: abs saturates, `gain_out`=0x6000, `audio_out`=−24576.
- Hold and release:
  - Stimulus: after 32767, feed zeros.
  - Required: `gain_out` stays 0x6000 for 240 samples, then rises monotonically to 0x8000 once env ≤ 24576.
- Busy and reset abort:
  - Stimulus: `sample_valid_in` at cycle 5 of processing; separately, `rst_in_n` pulsed during DIV.
  - Required: the extra sample is dropped with one `sample_valid_out` total; after the reset pulse, no strobe and outputs are at reset values.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio-path types, constants and helpers for the peak limiter.
package audio_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned GAIN_W   = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic        [GAIN_W-1:0]   gain_t;

    localparam gain_t   GAIN_UNITY = 16'h8000;
    localparam sample_t SAMPLE_MIN = 16'sh8000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENV,
        ST_DIV,
        ST_MUL,
        ST_OUT
    } limiter_state_t;

    // Magnitude of a sample; -32768 folds to 32767 so it fits the positive range.
    function automatic logic [SAMPLE_W-1:0] sat_abs(input sample_t x);
        if (x == SAMPLE_MIN) begin
            return 16'h7FFF;
        end else if (x[SAMPLE_W-1]) begin
            return 16'(-x);
        end else begin
            return 16'(x);
        end
    endfunction

endpackage

// File: rtl/peak_limiter_if.sv
// Sample stream into and out of the peak limiter.
interface peak_limiter_if;
    import audio_pkg::*;

    logic    sample_valid_in;
    sample_t audio_in;
    logic    sample_valid_out;
    sample_t audio_out;
    gain_t   gain_out;
    logic    limiting_out;

    modport master (
        output sample_valid_in, audio_in,
        input  sample_valid_out, audio_out, gain_out, limiting_out
    );

    modport slave (
        input  sample_valid_in, audio_in,
        output sample_valid_out, audio_out, gain_out, limiting_out
    );
endinterface

// File: rtl/serial_divider.sv
// Restoring radix-2 divider: 31-bit numerator / 16-bit denominator, 16 quotient
// bits in exactly 16 cycles after start; quotient saturates at 0x7FFF.
module serial_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [30:0] num,
    input  logic [15:0] den,
    output logic [15:0] quotient,
    output logic        done_c
);
    localparam int unsigned Q_W   = 16;
    localparam int unsigned CNT_W = $clog2(Q_W);

    logic             active_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      rem_q;
    logic [15:0]      bits_q;
    logic [15:0]      den_q;
    logic [15:0]      quo_q;
    logic             ovf_q;
    logic [16:0]      trial_c;
    logic             ge_c;
    logic [15:0]      final_c;

    // One restoring step: shift the next numerator bit into the remainder and try to subtract.
    always_comb begin
        trial_c = {rem_q, bits_q[15]};
        ge_c    = (trial_c >= {1'b0, den_q});
        final_c = {quo_q[14:0], ge_c};
        done_c  = active_q && (cnt_q == CNT_W'(Q_W - 1));
    end

    // Iteration registers; the top 15 numerator bits preload the remainder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            rem_q    <= '0;
            bits_q   <= '0;
            den_q    <= '0;
            quo_q    <= '0;
            ovf_q    <= 1'b0;
            quotient <= '0;
        end else if (start) begin
            active_q <= 1'b1;
            cnt_q    <= '0;
            rem_q    <= {1'b0, num[30:16]};
            bits_q   <= num[15:0];
            den_q    <= den;
            quo_q    <= '0;
            ovf_q    <= ({1'b0, num[30:16]} >= den);
        end else if (active_q) begin
            rem_q  <= ge_c ? 16'(trial_c - {1'b0, den_q}) : trial_c[15:0];
            bits_q <= {bits_q[14:0], 1'b0};
            quo_q  <= final_c;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (done_c) begin
                active_q <= 1'b0;
                quotient <= (ovf_q || final_c[15]) ? 16'h7FFF : final_c;
            end
        end
    end
endmodule

// File: rtl/peak_limiter.sv
// Per-sample peak limiter: envelope follower with hold/release, gain from a
// serial divider, bit-exact pass-through below threshold.
// Optional PEAK_LIMITER_STATS_EN adds a saturating count of attenuated samples.
module peak_limiter
    import audio_pkg::*;
#(
    parameter sample_t     THRESHOLD     = 16'sd24576,
    parameter int unsigned ATTACK_SHIFT  = 0,
    parameter int unsigned RELEASE_SHIFT = 10,
    parameter int unsigned HOLD_SAMPLES  = 240
) (
    input  logic                 audio_clk,
    input  logic                 rst_in_n,
    peak_limiter_if.slave        bus,
    output logic                 busy_out,
    output logic [15:0]          limit_count
);
    localparam int unsigned HOLD_W   = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;
    localparam logic [15:0] THRESH_U = THRESHOLD;
    localparam logic [30:0] DIV_NUM  = {THRESH_U, 15'd0};

    limiter_state_t    state_q;
    limiter_state_t    state_d;
    logic              div_start_c;
    logic              div_done_c;
    gain_t             div_quo;

    sample_t           sample_q;
    logic [15:0]       env_q;
    logic [15:0]       env_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic [15:0]       abs_c;
    logic [15:0]       rel_step_c;

    logic              limit_c;
    gain_t             gain_c;
    logic signed [32:0] prod_c;
    logic signed [32:0] shifted_c;
    sample_t           mul_out_c;

    serial_divider u_div (
        .clk      (audio_clk),
        .rst_n    (rst_in_n),
        .start    (div_start_c),
        .num      (DIV_NUM),
        .den      (env_d),
        .quotient (div_quo),
        .done_c   (div_done_c)
    );

    // State register.
    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    // Next state; the divider is launched from ENV with the freshly computed envelope.
    always_comb begin
        state_d     = state_q;
        div_start_c = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.sample_valid_in) state_d = ST_ENV;
            ST_ENV: begin
                div_start_c = 1'b1;
                state_d     = ST_DIV;
            end
            ST_DIV:  if (div_done_c) state_d = ST_MUL;
            ST_MUL:  state_d = ST_OUT;
            ST_OUT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Envelope follower: attack on rise, hold, then release floored at zero.
    always_comb begin
        abs_c      = sat_abs(sample_q);
        rel_step_c = env_q >> RELEASE_SHIFT;
        if (rel_step_c == 16'd0) rel_step_c = 16'd1;
        env_d  = env_q;
        hold_d = hold_q;
        if (abs_c > env_q) begin
            env_d  = env_q + ((abs_c - env_q) >> ATTACK_SHIFT);
            hold_d = HOLD_W'(HOLD_SAMPLES);
        end else if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
        end else begin
            env_d = (env_q > rel_step_c) ? (env_q - rel_step_c) : 16'd0;
        end
    end

    // Gain application: floor of x*gain/2^15, clamped to the sample range.
    always_comb begin
        limit_c   = (env_q > THRESH_U);
        gain_c    = limit_c ? div_quo : GAIN_UNITY;
        prod_c    = 33'(sample_q) * 33'($signed({1'b0, div_quo}));
        shifted_c = prod_c >>> 15;
        if (shifted_c > 33'sd32767)       mul_out_c = 16'sh7FFF;
        else if (shifted_c < -33'sd32768) mul_out_c = SAMPLE_MIN;
        else                              mul_out_c = shifted_c[15:0];
        if (!limit_c) mul_out_c = sample_q;
    end

    // Sample capture and envelope/hold state.
    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            sample_q <= '0;
            env_q    <= '0;
            hold_q   <= '0;
        end else begin
            if (state_q == ST_IDLE && bus.sample_valid_in) sample_q <= bus.audio_in;
            if (state_q == ST_ENV) begin
                env_q  <= env_d;
                hold_q <= hold_d;
            end
        end
    end

    // Output registers; results land as the FSM enters OUT.
    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            bus.audio_out        <= '0;
            bus.gain_out         <= GAIN_UNITY;
            bus.limiting_out     <= 1'b0;
            bus.sample_valid_out <= 1'b0;
            busy_out             <= 1'b0;
        end else begin
            bus.sample_valid_out <= (state_d == ST_OUT);
            busy_out             <= (state_d != ST_IDLE);
            if (state_q == ST_MUL) begin
                bus.audio_out    <= mul_out_c;
                bus.gain_out     <= gain_c;
                bus.limiting_out <= limit_c;
            end
        end
    end

`ifdef PEAK_LIMITER_STATS_EN
    logic [15:0] count_q;

    // Saturating count of attenuated output samples.
    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            count_q <= '0;
        end else if (state_q == ST_MUL && limit_c && count_q != 16'hFFFF) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign limit_count = count_q;
`else
    assign limit_count = '0;
`endif

endmodule

// File: tb/tb_peak_limiter.sv
// Scoreboard bench for peak_limiter: stimulus pushes model predictions, a
// negedge monitor pops and compares on every sample_valid_out.
module tb_peak_limiter;
    import audio_pkg::*;

    localparam sample_t     THR  = 16'sd24576;
    localparam int unsigned ATK  = 0;
    localparam int unsigned REL  = 10;
    localparam int unsigned HOLD = 240;
    localparam int          LAT  = 19;

    typedef struct {
        int audio;
        int gain;
        int lim;
        int cnt;
        int cyc;
    } exp_t;

    logic        audio_clk;
    logic        rst_in_n;
    logic        clk_run;
    logic        busy_out;
    logic [15:0] limit_count;

    peak_limiter_if bus();

    peak_limiter #(
        .THRESHOLD     (THR),
        .ATTACK_SHIFT  (ATK),
        .RELEASE_SHIFT (REL),
        .HOLD_SAMPLES  (HOLD)
    ) dut (
        .audio_clk   (audio_clk),
        .rst_in_n    (rst_in_n),
        .bus         (bus),
        .busy_out    (busy_out),
        .limit_count (limit_count)
    );

    int   total;
    int   bad;
    int   cyc;
    int   strobe_cnt;
    int   last_issue;
    int   m_env;
    int   m_hold;
    int   m_cnt;
    int   prev_gain;
    bit   rel_mon;
    exp_t sb[$];
    exp_t mon_e;

    initial begin
        audio_clk = 1'b0;
        forever #5 audio_clk = clk_run ? ~audio_clk : 1'b0;
    end

    always @(posedge audio_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: envelope rules and gain law in plain integer arithmetic.
    function automatic void model_step(input int x, output int out, output int gain, output int lim);
        int  a;
        int  d;
        longint p;
        longint q;
        a = (x < 0) ? -x : x;
        if (a > 32767) a = 32767;
        if (a > m_env) begin
            m_env  = m_env + ((a - m_env) >> ATK);
            m_hold = HOLD;
        end else if (m_hold > 0) begin
            m_hold = m_hold - 1;
        end else begin
            d = m_env >> REL;
            if (d < 1) d = 1;
            m_env = (m_env > d) ? m_env - d : 0;
        end
        if (m_env > int'(THR)) begin
            gain = (int'(THR) * 32768) / m_env;
            if (gain > 32767) gain = 32767;
            lim = 1;
            p = longint'(x) * longint'(gain);
            q = p / 32768;
            if ((p % 32768) != 0 && p < 0) q = q - 1;
            if (q > 32767) q = 32767;
            if (q < -32768) q = -32768;
            out = int'(q);
`ifdef PEAK_LIMITER_STATS_EN
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
`endif
        end else begin
            gain = 32768;
            lim  = 0;
            out  = x;
        end
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge audio_clk);
    endtask

    // Drive one strobe after 'lead' negedges; accepted samples go to the scoreboard.
    task automatic send(input int x, input bit acc, input int lead);
        exp_t e;
        int o;
        int g;
        int l;
        repeat (lead) @(negedge audio_clk);
        bus.sample_valid_in = 1'b1;
        bus.audio_in        = 16'(x);
        if (acc) begin
            model_step(x, o, g, l);
            e.audio = o;
            e.gain  = g;
            e.lim   = l;
            e.cnt   = m_cnt;
            e.cyc   = cyc;
            last_issue = cyc;
            sb.push_back(e);
        end
        @(negedge audio_clk);
        bus.sample_valid_in = 1'b0;
    endtask

    function automatic int rand_sample();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 4000)) - 2000;
            1:       return int'($urandom_range(0, 52000)) - 26000;
            2:       return ($urandom_range(0, 1) == 0) ? 32767 : -32768;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    // Monitor: compare every output strobe against the oldest prediction.
    always @(negedge audio_clk) begin
        if (bus.sample_valid_out) begin
            strobe_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_valid_out", int'(bus.sample_valid_out), 0);
            end else begin
                mon_e = sb.pop_front();
                check("latency", cyc, mon_e.cyc + LAT);
                check("audio_out", int'(bus.audio_out), mon_e.audio);
                check("gain_out", int'(bus.gain_out), mon_e.gain);
                check("limiting_out", int'(bus.limiting_out), mon_e.lim);
                check("limit_count", int'(limit_count), mon_e.cnt);
                check("busy_at_out", int'(busy_out), 1);
                if (rel_mon) begin
                    check("release_monotonic", int'(int'(bus.gain_out) >= prev_gain), 1);
                    prev_gain = int'(bus.gain_out);
                end
            end
        end else if (sb.size() != 0 && cyc > sb[0].cyc + LAT) begin
            check("missing_valid_out", int'(bus.sample_valid_out), 1);
            void'(sb.pop_front());
        end
    end

    initial begin
        int s0;
        int lead;
        int gap;
        int k;
        total      = 0;
        bad        = 0;
        cyc        = 0;
        strobe_cnt = 0;
        last_issue = 0;
        m_env      = 0;
        m_hold     = 0;
        m_cnt      = 0;
        prev_gain  = 0;
        rel_mon    = 1'b0;
        clk_run    = 1'b0;
        rst_in_n   = 1'b1;
        bus.sample_valid_in = 1'b0;
        bus.audio_in        = '0;

        // Reset with the clock stopped.
        #2 rst_in_n = 1'b0;
        #5;
        check("rst_audio_out", int'(bus.audio_out), 0);
        check("rst_gain_out", int'(bus.gain_out), 32768);
        check("rst_valid_out", int'(bus.sample_valid_out), 0);
        check("rst_limiting", int'(bus.limiting_out), 0);
        check("rst_busy", int'(busy_out), 0);
        check("rst_limit_count", int'(limit_count), 0);
        #1 rst_in_n = 1'b1;
        clk_run = 1'b1;
        wait_cycles(3);

        // Sub-threshold sample, with busy window checks.
        send(1000, 1'b1, 0);
        check("busy_cycle1", int'(busy_out), 1);
        wait_cycles(18);
        check("busy_cycle19", int'(busy_out), 1);
        wait_cycles(1);
        check("busy_cycle20", int'(busy_out), 0);
        check("sub_audio", int'(bus.audio_out), 1000);
        check("sub_gain", int'(bus.gain_out), 32768);

        // Positive then negative full scale.
        send(32767, 1'b1, 0);
        wait_cycles(19);
        check("pfs_gain", int'(bus.gain_out), 24576);
        check("pfs_audio", int'(bus.audio_out), 24575);
        check("pfs_limiting", int'(bus.limiting_out), 1);
        send(-32768, 1'b1, 0);
        wait_cycles(19);
        check("nfs_gain", int'(bus.gain_out), 24576);
        check("nfs_audio", int'(bus.audio_out), -24576);

        // Hold then release on zeros.
        prev_gain = 24576;
        rel_mon   = 1'b1;
        for (int i = 0; i < 600; i++) begin
            send(0, 1'b1, 0);
            wait_cycles(19);
        end
        rel_mon = 1'b0;
        check("release_end_gain", int'(bus.gain_out), 32768);
        check("release_end_limiting", int'(bus.limiting_out), 0);

        // Strobes while busy and in the OUT cycle are dropped; the next cycle accepts.
        s0 = strobe_cnt;
        send(500, 1'b1, 0);
        wait_cycles(3);
        send(7777, 1'b0, 1);
        wait_cycles(13);
        send(-1234, 1'b0, 0);
        send(2345, 1'b1, 0);
        wait_cycles(19);
        check("drop_strobe_count", strobe_cnt - s0, 2);

        // Reset pulse during DIV aborts the sample.
        send(30000, 1'b1, 0);
        wait_cycles(7);
        @(posedge audio_clk);
        #2 rst_in_n = 1'b0;
        sb.delete();
        m_env  = 0;
        m_hold = 0;
        m_cnt  = 0;
        @(posedge audio_clk);
        #2 rst_in_n = 1'b1;
        @(negedge audio_clk);
        check("abort_audio_out", int'(bus.audio_out), 0);
        check("abort_gain_out", int'(bus.gain_out), 32768);
        check("abort_busy", int'(busy_out), 0);
        check("abort_limiting", int'(bus.limiting_out), 0);
        check("abort_limit_count", int'(limit_count), 0);
        s0 = strobe_cnt;
        wait_cycles(30);
        check("abort_no_strobe", strobe_cnt - s0, 0);

        // Randomized traffic with occasional dropped strobes.
        last_issue = cyc - 20;
        for (int i = 0; i < 300; i++) begin
            gap  = int'($urandom_range(0, 4));
            lead = last_issue + 20 + gap - cyc;
            if (lead < 0) lead = 0;
            send(rand_sample(), 1'b1, lead);
            if ($urandom_range(0, 3) == 0) begin
                k    = int'($urandom_range(1, 19));
                lead = last_issue + k - cyc;
                if (lead < 0) lead = 0;
                send(rand_sample(), 1'b0, lead);
            end
        end

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge audio_clk);
        check("drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
